// File: rtl/ipv4_vlg_pkg.sv
// Shared types for the IPv4 TX arbiter: metadata layout and arbiter FSM states.
package ipv4_vlg_pkg;

  localparam int META_W = 56;

  typedef struct packed {
    logic [31:0] dst_ip;
    logic [7:0]  proto;
    logic [15:0] pld_len;
  } arb_meta_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } arb_fsm_t;

endpackage

// File: rtl/eth_vlg_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N.
module eth_vlg_rr_pick #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int c;

  // Scan from the farthest offset down so the nearest hit to ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/ipv4_vlg_tx_arb.sv
// Round-robin arbiter granting the IPv4 TX core to one of N upper-layer requesters per packet.
module ipv4_vlg_tx_arb
  import ipv4_vlg_pkg::*;
#(
  parameter  int N          = 3,
  parameter  int GAP_CYCLES = 2,
  parameter  int TIMEOUT    = 65535,
  localparam int IW         = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_rdy,
  input  logic [N*56-1:0]   req_meta,
  input  logic [N*8-1:0]    req_dat,
  output logic [N-1:0]      req_acc,
  output logic [N-1:0]      req_dat_req,
  output logic [N-1:0]      req_done,
  output logic              out_rdy,
  output logic [55:0]       out_meta,
  input  logic              out_acc,
  input  logic              out_dat_req,
  output logic [7:0]        out_dat,
  input  logic              out_done,
  output logic [IW-1:0]     gnt_idx,
  output logic              busy,
  output logic              tmo
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam arb_fsm_t    POST_PKT = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_fsm_t        state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   ptr_nxt;
  logic [N-1:0]    sel_oh;
  arb_meta_t       meta_sel;
  logic [7:0]      dat_sel;
  logic            rdy_sel;
  logic            tmo_hit;
  logic            acc_c, done_c, tmo_c;

  eth_vlg_rr_pick #(.N(N)) u_pick (
    .req   (req_rdy),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    meta_sel = '0;
    dat_sel  = '0;
    rdy_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == IW'(i)) begin
        meta_sel = req_meta[META_W*i +: META_W];
        dat_sel  = req_dat[8*i +: 8];
        rdy_sel  = req_rdy[i];
      end
    end
  end

  assign sel_oh  = N'(1) << sel_q;
  assign ptr_nxt = (sel_q == IW'(N - 1)) ? '0 : sel_q + 1'b1;
  assign tmo_hit = (cnt_q == TMO_LAST);

  // Priority in GRANT: accept, then withdrawal, then timeout. In XFER a real done beats timeout.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    acc_c   = 1'b0;
    done_c  = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick_idx;
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 16'd1;
        if (out_acc) begin
          acc_c   = 1'b1;
          state_d = XFER;
          cnt_d   = '0;
        end else if (!rdy_sel) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_c   = 1'b1;
          done_c  = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = POST_PKT;
          cnt_d   = '0;
        end
      end
      XFER: begin
        cnt_d = cnt_q + 16'd1;
        if (out_done || tmo_hit) begin
          tmo_c   = !out_done;
          done_c  = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = POST_PKT;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_rdy     = (state_q == GRANT);
  assign out_meta    = out_rdy ? meta_sel : '0;
  assign out_dat     = (state_q == XFER) ? dat_sel : 8'd0;
  assign req_dat_req = (state_q == XFER && out_dat_req) ? sel_oh : '0;
  assign req_acc     = acc_c  ? sel_oh : '0;
  assign req_done    = done_c ? sel_oh : '0;
  assign tmo         = tmo_c;
  assign gnt_idx     = sel_q;
  assign busy        = (state_q != IDLE);

endmodule
